// File: rtl/ram_dump_unit_pkg.sv
// ram_dump_unit_pkg: shared state encoding and constants for the RAM dump unit.
package ram_dump_unit_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;
    localparam int RAM_BYTES = 256;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_W = $clog2(RAM_BYTES);
    localparam logic [ADDR_W-1:0] CHECKSUM_ADDR = 8'hFF;
endpackage

// File: rtl/ram_dump_unit_if.sv
// ram_dump_unit_if: control, RAM-port and output-stream signals of the dump unit.
interface ram_dump_unit_if;
    import ram_dump_unit_pkg::*;
    logic              start;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              mem_E;
    logic              mem_RW;
    logic              mem_Size;
    logic [ADDR_W-1:0] mem_A;
    logic [31:0]       mem_DO;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    modport master (
        input  start, mem_DO, out_ready,
        output cpu_hold, busy, done, mem_E, mem_RW, mem_Size, mem_A,
               out_valid, out_data, out_addr, out_last
    );
    modport slave (
        output start, mem_DO, out_ready,
        input  cpu_hold, busy, done, mem_E, mem_RW, mem_Size, mem_A,
               out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/ram_dump_unit_dump_addr_gen.sv
// dump_addr_gen: byte address and word counter for the dump walk; the address wraps modulo 256.
module dump_addr_gen
    import ram_dump_unit_pkg::*;
#(
    parameter int WORD_COUNT = 64
) (
    input  logic              clk,
    input  logic              R,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              is_last
);
    localparam int CW = $clog2(WORD_COUNT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!R) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= start_addr;
            cnt  <= '0;
        end else if (step) begin
            addr <= addr + ADDR_W'(WORD_BYTES);
            cnt  <= cnt + CW'(1);
        end
    end
    assign is_last = cnt == CW'(WORD_COUNT - 1);
endmodule

// File: rtl/ram_dump_unit.sv
// ram_dump_unit: holds the CPU and streams data-RAM words with their addresses over valid/ready.
// Define DUMP_CHECKSUM_EN to append a 32-bit wrap-around sum beat at address 8'hFF.
module ram_dump_unit
    import ram_dump_unit_pkg::*;
#(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int WORD_COUNT = 64
) (
    input logic clk,
    input logic R,
    ram_dump_unit_if.master bus
);
`ifdef DUMP_CHECKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif
    state_t state;
    logic [ADDR_W-1:0] addr;
    logic is_last;
    logic load;
    logic step;
    logic fire;
    logic final_beat;
    assign fire = bus.out_valid & bus.out_ready;
    assign load = state == IDLE && bus.start;
    assign bus.mem_RW = 1'b0;
    assign bus.mem_Size = 1'b1;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] sum;
    logic sum_beat;
    assign final_beat = sum_beat;
    assign step = state == SEND && fire && !sum_beat;
`else
    assign final_beat = is_last;
    assign step = state == SEND && fire;
`endif
    dump_addr_gen #(.WORD_COUNT(WORD_COUNT)) u_addr_gen (
        .clk       (clk),
        .R         (R),
        .load      (load),
        .step      (step),
        .start_addr(START_ADDR),
        .addr      (addr),
        .is_last   (is_last)
    );
    always_ff @(posedge clk) begin
        if (!R) begin
            state         <= IDLE;
            bus.cpu_hold  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mem_E     <= 1'b0;
            bus.mem_A     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum           <= '0;
            sum_beat      <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state        <= READ;
                    bus.cpu_hold <= 1'b1;
                    bus.busy     <= 1'b1;
                    bus.mem_E    <= 1'b1;
                    bus.mem_A    <= START_ADDR;
`ifdef DUMP_CHECKSUM_EN
                    sum          <= '0;
                    sum_beat     <= 1'b0;
`endif
                end
                READ: begin
                    state         <= SEND;
                    bus.mem_E     <= 1'b0;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= bus.mem_DO;
                    bus.out_addr  <= addr;
                    bus.out_last  <= is_last & ~CKS_EN;
                end
                SEND: if (fire) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    if (!sum_beat) sum <= sum + bus.out_data;
`endif
                    if (final_beat) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        sum_beat <= 1'b0;
                    end else if (is_last) begin
                        // checksum beat follows the last data word directly, without a READ cycle
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= sum + bus.out_data;
                        bus.out_addr  <= CHECKSUM_ADDR;
                        bus.out_last  <= 1'b1;
                        sum_beat      <= 1'b1;
`endif
                    end else begin
                        state     <= READ;
                        bus.mem_E <= 1'b1;
                        bus.mem_A <= addr + ADDR_W'(WORD_BYTES);
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.cpu_hold <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_dump_unit.sv
// tb_ram_dump_unit: randomized scoreboard bench for two dump units (START 00/4 words and F8/3 words).
module tb_ram_dump_unit;
    import ram_dump_unit_pkg::*;
`ifdef DUMP_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif
    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic ra = 1'b0;
    logic rb = 1'b0;
    ram_dump_unit_if ia ();
    ram_dump_unit_if ib ();
    ram_dump_unit #(.START_ADDR(8'h00), .WORD_COUNT(4)) dut_a (.clk(clk), .R(ra), .bus(ia));
    ram_dump_unit #(.START_ADDR(8'hF8), .WORD_COUNT(3)) dut_b (.clk(clk), .R(rb), .bus(ib));

    logic [31:0] ram [64];
    assign ia.mem_DO = ram[ia.mem_A[7:2]];
    assign ib.mem_DO = ram[ib.mem_A[7:2]];

    beat_t qa[$];
    beat_t qb[$];
    int errs = 0;
    int checks = 0;
    int exp_done_a = 0;
    int exp_done_b = 0;
    int dones_a = 0;
    int dones_b = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: the dump is the word at each of count consecutive word addresses, modulo 256.
    function automatic void push_exp(input bit b);
        logic [7:0] a;
        logic [31:0] s;
        int cnt;
        beat_t e;
        a = b ? 8'hF8 : 8'h00;
        cnt = b ? 3 : 4;
        s = 0;
        for (int i = 0; i < cnt; i++) begin
            e.a = a;
            e.d = ram[a[7:2]];
            e.l = (i == cnt - 1) && !CKS;
            s = s + e.d;
            if (b) qb.push_back(e); else qa.push_back(e);
            a = a + 8'd4;
        end
        if (CKS) begin
            e.a = 8'hFF;
            e.d = s;
            e.l = 1'b1;
            if (b) qb.push_back(e); else qa.push_back(e);
        end
        if (b) exp_done_b++; else exp_done_a++;
    endfunction

    function automatic logic [63:0] outs_a();
        return {ia.busy, ia.cpu_hold, ia.done, ia.mem_E, ia.out_valid, ia.out_last,
                ia.mem_A, ia.out_addr, ia.out_data};
    endfunction
    function automatic logic [63:0] outs_b();
        return {ib.busy, ib.cpu_hold, ib.done, ib.mem_E, ib.out_valid, ib.out_last,
                ib.mem_A, ib.out_addr, ib.out_data};
    endfunction

    logic stall_a = 1'b0, last_a = 1'b0;
    logic [40:0] pa;
    always @(negedge clk) begin
        if (!ra) begin
            stall_a = 1'b0;
            last_a = 1'b0;
        end else begin
            beat_t e;
            if (stall_a) chk("a_stall_hold", {ia.out_valid, ia.out_last, ia.out_addr, ia.out_data}, {1'b1, pa});
            if (ia.done || last_a) chk("a_done_after_last", ia.done, last_a);
            if (ia.done) dones_a++;
            if (ia.out_valid && ia.out_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL a_extra_beat: got addr %h data %h expected none", ia.out_addr, ia.out_data);
                end else begin
                    e = qa.pop_front();
                    chk("a_beat", {ia.out_last, ia.out_addr, ia.out_data}, {e.l, e.a, e.d});
                end
            end
            last_a = ia.out_valid && ia.out_ready && ia.out_last;
            stall_a = ia.out_valid && !ia.out_ready;
            pa = {ia.out_last, ia.out_addr, ia.out_data};
        end
    end

    logic stall_b = 1'b0, last_b = 1'b0;
    logic [40:0] pb;
    always @(negedge clk) begin
        if (!rb) begin
            stall_b = 1'b0;
            last_b = 1'b0;
        end else begin
            beat_t e;
            if (stall_b) chk("b_stall_hold", {ib.out_valid, ib.out_last, ib.out_addr, ib.out_data}, {1'b1, pb});
            if (ib.done || last_b) chk("b_done_after_last", ib.done, last_b);
            if (ib.done) dones_b++;
            if (ib.out_valid && ib.out_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL b_extra_beat: got addr %h data %h expected none", ib.out_addr, ib.out_data);
                end else begin
                    e = qb.pop_front();
                    chk("b_beat", {ib.out_last, ib.out_addr, ib.out_data}, {e.l, e.a, e.d});
                end
            end
            last_b = ib.out_valid && ib.out_ready && ib.out_last;
            stall_b = ib.out_valid && !ib.out_ready;
            pb = {ib.out_last, ib.out_addr, ib.out_data};
        end
    end

    task automatic do_dump(input bit b, input int pct);
        int n;
        push_exp(b);
        @(posedge clk); #1;
        if (b) ib.start = 1'b1; else ia.start = 1'b1;
        @(posedge clk); #1;
        if (b) ib.start = 1'b0; else ia.start = 1'b0;
        n = 0;
        while (!(b ? ib.done : ia.done) && n < 2000) begin
            if (b) ib.out_ready = $urandom_range(99) < pct;
            else ia.out_ready = $urandom_range(99) < pct;
            @(posedge clk); #1;
            n++;
        end
        chk(b ? "b_done_in_time" : "a_done_in_time", 64'(n < 2000), 64'd1);
        if (b) ib.out_ready = 1'b1; else ia.out_ready = 1'b1;
    endtask

    task automatic wait_done_a(input string nm);
        int n;
        n = 0;
        while (!ia.done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 64'(n < 200), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        ia.start = 1'b0;
        ib.start = 1'b0;
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs_a", outs_a(), 64'd0);
        chk("rst_outs_b", outs_b(), 64'd0);
        chk("rst_rw_size_a", {ia.mem_RW, ia.mem_Size}, 2'b01);
        chk("rst_rw_size_b", {ib.mem_RW, ib.mem_Size}, 2'b01);
        ra = 1'b1;
        rb = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs_a", outs_a(), 64'd0);

        // directed dump with latency checks, ready held high
        push_exp(0);
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        chk("lat_read", {ia.busy, ia.cpu_hold, ia.mem_E, ia.out_valid, ia.mem_A}, {4'b1110, 8'h00});
        @(posedge clk); #1;
        chk("lat_send", {ia.mem_E, ia.out_valid}, 2'b01);
        k = 2;
        while (!ia.done && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("lat_done", 64'(k), 64'(9 + int'(CKS)));
        chk("done_busy", {ia.busy, ia.cpu_hold}, 2'b11);
        @(posedge clk); #1;
        chk("idle_after_done", {ia.busy, ia.cpu_hold, ia.done, ia.out_valid}, 4'b0000);

        // stall beat 2 for several cycles
        push_exp(0);
        @(posedge clk); #1 ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ia.out_valid && ia.out_ready) && k < 20);
        @(posedge clk); #1 ia.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 ia.out_ready = 1'b1;
        wait_done_a("stall_done");

        // reset while beat 2 is in SEND
        push_exp(0);
        @(posedge clk); #1 ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ia.out_valid && ia.out_ready) && k < 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_send", {ia.out_valid, ia.out_addr}, {1'b1, 8'h04});
        ra = 1'b0;
        ia.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_outs", outs_a(), 64'd0);
        qa.delete();
        exp_done_a--;
        ra = 1'b1;
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", {ia.done, ia.busy}, 2'b00);
        do_dump(0, 100);

        // start pulses while busy and during DONE are ignored
        push_exp(0);
        @(posedge clk); #1 ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        wait_done_a("ign_done");
        ia.start = 1'b1;
        @(posedge clk); #1 ia.start = 1'b0;
        chk("ign_idle", {ia.busy, ia.mem_E}, 2'b00);
        repeat (3) @(posedge clk);
        #1 chk("ign_still_idle", {ia.busy, ia.out_valid}, 2'b00);

        // checksum pattern, including a wrapping word
        ram[0] = 32'h1;
        ram[1] = 32'h2;
        ram[2] = 32'h3;
        ram[3] = 32'hFFFF_FFFF;
        do_dump(0, 100);

        // randomized data and backpressure on both units, b wraps past FC
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 64; i++) ram[i] = $urandom;
            fork
                do_dump(0, int'($urandom_range(100, 20)));
                do_dump(1, int'($urandom_range(100, 20)));
            join
        end

        repeat (4) @(posedge clk);
        #1;
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        chk("a_done_count", 64'(dones_a), 64'(exp_done_a));
        chk("b_done_count", 64'(dones_b), 64'(exp_done_b));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
